// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I/J fields into 32-bit words and streams them
// into a 1024-word instruction memory, one registered write per accepted request.
module instr_encoder (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_valid,
  output logic        out_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_we,
  output logic [9:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_done,
  output logic        out_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'h3FF;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        handshake_s;

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (fmt)
      2'd0:    word = {6'b000000, rs, rt, rd, shamt, op};
      2'd1:    word = {op, rs, rt, imm};
      2'd2:    word = {op, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // I and J formats reserve opcode 0 for the R-format space, so it is illegal there.
  function automatic logic is_legal(input logic [1:0] fmt, input logic [5:0] op);
    logic ok;
    case (fmt)
      2'd0:       ok = 1'b1;
      2'd1, 2'd2: ok = (op != 6'd0);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign handshake_s = in_valid && ready_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          if (is_legal(in_fmt, in_op)) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            data_d  = encode(in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
            last_d  = in_last;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 10'd1;
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 10'd0;
      data_q  <= 32'h0000_0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign out_ready = ready_q;
  assign out_we    = we_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_done  = done_q;
  assign out_err   = err_q;

endmodule
